// File: rtl/mul_pkg.sv
// Shared constants and entry record for the Booth multiplier result path.
package mul_pkg;

    localparam int unsigned PW = 64;
    localparam int unsigned RW = 32;

    localparam logic [RW-1:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [RW-1:0] SAT_NEG = 32'h8000_0000;

    // One buffered result: narrowed value, raw upper half, overflow and saturation flags.
    typedef struct packed {
        logic [RW-1:0] res;
        logic [RW-1:0] hi;
        logic          ovf;
        logic          satd;
    } mul_entry_t;

endpackage

// File: rtl/mul_narrow_sat.sv
// Narrows a signed PW-bit product to RW bits, flags overflow and optionally saturates.
module mul_narrow_sat
    import mul_pkg::*;
(
    input  logic [PW-1:0] prod_i,
    input  logic          sat_i,
    output mul_entry_t    entry_o
);

    // Bits that must all match the result sign bit for the value to fit in RW bits.
    logic [RW:0] sign_bits;
    logic        ovf;

    assign sign_bits = prod_i[PW-1:RW-1];
    assign ovf       = !((&sign_bits) || !(|sign_bits));

    // Build the entry record; saturation direction follows the product sign.
    always_comb begin
        entry_o      = '0;
        entry_o.hi   = prod_i[PW-1:RW];
        entry_o.ovf  = ovf;
        entry_o.satd = ovf && sat_i;
        if (ovf && sat_i) begin
            entry_o.res = prod_i[PW-1] ? SAT_NEG : SAT_POS;
        end else begin
            entry_o.res = prod_i[RW-1:0];
        end
    end

endmodule

// File: rtl/mul_result_buffer.sv
// Result FIFO behind the Booth multiplier: narrows/saturates each accepted product,
// buffers DEPTH entries with valid/ready on both sides and keeps a sticky overflow flag.
// Product and result widths are the package constants PW and RW.
module mul_result_buffer
    import mul_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [PW-1:0]            in_prod_i,
    input  logic                     in_sat_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [RW-1:0]            out_res_o,
    output logic [RW-1:0]            out_hi_o,
    output logic                     out_ovf_o,
    output logic                     out_satd_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ovf_sticky_o,
    input  logic                     clr_sticky_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    mul_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          sticky_q, sticky_d;

    mul_entry_t    new_entry;
    mul_entry_t    head;
    logic          full, empty, push, pop;

    mul_narrow_sat u_narrow (
        .prod_i  (in_prod_i),
        .sat_i   (in_sat_i),
        .entry_o (new_entry)
    );

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign push  = in_valid_i && !full;
    assign pop   = !empty && out_ready_i;
    assign head  = mem_q[rd_ptr_q];

    // Pointer, occupancy and sticky-flag next state; set beats clear on the sticky flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        sticky_d = (sticky_q && !clr_sticky_i) || (push && new_entry.ovf);
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset; queued entries are simply abandoned.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    // Entry storage; no reset needed because outputs are masked while empty.
    always_ff @(posedge clk_i) begin
        if (push && !reset_i) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    // Head outputs read zero whenever the buffer is empty.
    always_comb begin
        in_ready_o   = !full;
        out_valid_o  = !empty;
        count_o      = count_q;
        ovf_sticky_o = sticky_q;
        out_res_o    = '0;
        out_hi_o     = '0;
        out_ovf_o    = 1'b0;
        out_satd_o   = 1'b0;
        if (!empty) begin
            out_res_o  = head.res;
            out_hi_o   = head.hi;
            out_ovf_o  = head.ovf;
            out_satd_o = head.satd;
        end
    end

endmodule

// File: tb/tb_mul_result_buffer.sv
// Directed self-checking bench for mul_result_buffer.
module tb_mul_result_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_prod;
    logic        in_sat;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [31:0] out_hi;
    logic        out_ovf;
    logic        out_satd;
    logic [2:0]  count;
    logic        ovf_sticky;
    logic        clr_sticky;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_result_buffer #(.DEPTH(4)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_prod_i    (in_prod),
        .in_sat_i     (in_sat),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_res_o    (out_res),
        .out_hi_o     (out_hi),
        .out_ovf_o    (out_ovf),
        .out_satd_o   (out_satd),
        .count_o      (count),
        .ovf_sticky_o (ovf_sticky),
        .clr_sticky_i (clr_sticky)
    );

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [63:0] p, input logic s);
        in_valid = 1'b1;
        in_prod  = p;
        in_sat   = s;
        step();
        in_valid = 1'b0;
        in_prod  = 'x;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", count); end
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL rst_sticky: got %b exp 0", ovf_sticky); end
        checks++; if ({out_res, out_hi, out_ovf, out_satd} !== 66'd0) begin errors++; $display("FAIL rst_outputs_zero: got %h_%h_%b%b exp 0", out_res, out_hi, out_ovf, out_satd); end
    endtask

    task automatic test_basic();
        push_one(64'h0000_0000_0000_0006, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b exp 1", out_valid); end
        checks++; if (out_res !== 32'd6) begin errors++; $display("FAIL basic_res: got %h exp 00000006", out_res); end
        checks++; if (out_hi !== 32'd0 || out_ovf !== 1'b0) begin errors++; $display("FAIL basic_hi_ovf: got %h/%b exp 00000000/0", out_hi, out_ovf); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL basic_count: got %0d exp 1", count); end
        pop_one();
        checks++; if (out_valid !== 1'b0 || out_res !== 32'd0) begin errors++; $display("FAIL basic_empty: got %b/%h exp 0/00000000", out_valid, out_res); end
    endtask

    task automatic test_negative();
        push_one(64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
        checks++; if (out_res !== 32'hFFFF_FFFA) begin errors++; $display("FAIL neg_res: got %h exp fffffffa", out_res); end
        checks++; if (out_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL neg_hi: got %h exp ffffffff", out_hi); end
        checks++; if (out_ovf !== 1'b0 || out_satd !== 1'b0) begin errors++; $display("FAIL neg_flags: got %b%b exp 00", out_ovf, out_satd); end
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL neg_sticky: got %b exp 0", ovf_sticky); end
        pop_one();
    endtask

    task automatic test_saturate();
        push_one(64'h0000_0001_0000_0000, 1'b1);
        checks++; if (out_res !== 32'h7FFF_FFFF) begin errors++; $display("FAIL satpos_res: got %h exp 7fffffff", out_res); end
        checks++; if (out_hi !== 32'h0000_0001) begin errors++; $display("FAIL satpos_hi: got %h exp 00000001", out_hi); end
        checks++; if (out_ovf !== 1'b1 || out_satd !== 1'b1) begin errors++; $display("FAIL satpos_flags: got %b%b exp 11", out_ovf, out_satd); end
        checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL satpos_sticky: got %b exp 1", ovf_sticky); end
        pop_one();
        push_one(64'h0000_0001_0000_0000, 1'b0);
        checks++; if (out_res !== 32'd0) begin errors++; $display("FAIL trunc_res: got %h exp 00000000", out_res); end
        checks++; if (out_ovf !== 1'b1 || out_satd !== 1'b0) begin errors++; $display("FAIL trunc_flags: got %b%b exp 10", out_ovf, out_satd); end
        pop_one();
        push_one(64'hFFFF_FFFE_0000_0000, 1'b1);
        checks++; if (out_res !== 32'h8000_0000) begin errors++; $display("FAIL satneg_res: got %h exp 80000000", out_res); end
        checks++; if (out_hi !== 32'hFFFF_FFFE || out_satd !== 1'b1) begin errors++; $display("FAIL satneg_hi_satd: got %h/%b exp fffffffe/1", out_hi, out_satd); end
        pop_one();
        // Boundary: bit 31 set with zero upper half does not fit.
        push_one(64'h0000_0000_8000_0000, 1'b1);
        checks++; if (out_ovf !== 1'b1 || out_res !== 32'h7FFF_FFFF) begin errors++; $display("FAIL edge_pos: got %b/%h exp 1/7fffffff", out_ovf, out_res); end
        pop_one();
        // Boundary: most negative RW value fits.
        push_one(64'hFFFF_FFFF_8000_0000, 1'b1);
        checks++; if (out_ovf !== 1'b0 || out_res !== 32'h8000_0000) begin errors++; $display("FAIL edge_neg: got %b/%h exp 0/80000000", out_ovf, out_res); end
        pop_one();
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clear: got %b exp 0", ovf_sticky); end
    endtask

    task automatic test_full();
        logic [31:0] exp_vals [4];
        exp_vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_one({32'd0, exp_vals[i]}, 1'b0);
        end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d exp 4", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b exp 0", in_ready); end
        push_one(64'h55, 1'b0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_reject_count: got %0d exp 4", count); end
        checks++; if (out_res !== 32'h11) begin errors++; $display("FAIL full_stall_head: got %h exp 00000011", out_res); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_res !== exp_vals[i]) begin errors++; $display("FAIL full_order[%0d]: got %b/%h exp 1/%h", i, out_valid, out_res, exp_vals[i]); end
            pop_one();
        end
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL full_drained: got %b/%0d exp 0/0", out_valid, count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_head;
        push_one(64'd1000, 1'b0);
        push_one(64'd1001, 1'b0);
        for (int i = 0; i < 10; i++) begin
            exp_head = (i == 0) ? 32'd1000 : (i == 1) ? 32'd1001 : 32'(100 + i - 2);
            checks++; if (out_res !== exp_head) begin errors++; $display("FAIL b2b_head[%0d]: got %0d exp %0d", i, out_res, exp_head); end
            in_valid  = 1'b1;
            in_prod   = 64'(100 + i);
            in_sat    = 1'b0;
            out_ready = 1'b1;
            step();
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count[%0d]: got %0d exp 2", i, count); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (out_res !== 32'd108) begin errors++; $display("FAIL b2b_tail0: got %0d exp 108", out_res); end
        pop_one();
        checks++; if (out_res !== 32'd109) begin errors++; $display("FAIL b2b_tail1: got %0d exp 109", out_res); end
        pop_one();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b exp 0", out_valid); end
    endtask

    task automatic test_sticky_and_reset();
        clr_sticky = 1'b1;
        push_one(64'h0000_0001_0000_0000, 1'b0);
        clr_sticky = 1'b0;
        checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set_wins: got %b exp 1", ovf_sticky); end
        push_one(64'd7, 1'b0);
        push_one(64'd8, 1'b0);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL pre_reset_count: got %0d exp 3", count); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL midreset_state: got %0d/%b exp 0/0", count, out_valid); end
        checks++; if (ovf_sticky !== 1'b0 || out_res !== 32'd0) begin errors++; $display("FAIL midreset_sticky_res: got %b/%h exp 0/00000000", ovf_sticky, out_res); end
        push_one(64'd9, 1'b0);
        checks++; if (out_res !== 32'd9 || count !== 3'd1) begin errors++; $display("FAIL post_reset_push: got %0d/%0d exp 9/1", out_res, count); end
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_prod    = 'x;
        in_sat     = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_negative();
        test_saturate();
        test_full();
        test_back_to_back();
        test_sticky_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
